// File: rtl/rom_arb.sv
// rom_arb: round-robin two-port arbiter and response register in front of the single-port instruction ROM.
// Grant in cycle N gives a response in N+1; a port is granted only when its response slot can drain that cycle.
module rom_arb #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_i,
    input  logic [1:0][AW-1:0]   addr_i,
    output logic [1:0]           gnt_o,
    output logic [1:0]           rvalid_o,
    output logic [1:0][31:0]     rdata_o,
    output logic [1:0]           rerr_o,
    input  logic [1:0]           rready_i,
    output logic                 rom_en_o,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [31:0]          rom_instr_i
);

    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        rerr_q, rerr_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic              last_q, last_d;
    logic [1:0]        elig;
    logic [AW-1:0]     sel_addr;
    logic              bad;

    always_comb begin
        // A slot is usable if empty or being consumed this very cycle.
        elig = req_i & (~rvalid_q | rready_i) & {2{~rst_i}};
        gnt_o = elig;
        if (elig == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        sel_addr   = gnt_o[1] ? addr_i[1] : (gnt_o[0] ? addr_i[0] : '0);
        bad        = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= AW'(DEPTH));
        rom_en_o   = (|gnt_o) && !bad;
        rom_addr_o = sel_addr;
        last_d     = (|gnt_o) ? gnt_o[1] : last_q;

        rvalid_d = rvalid_q;
        rerr_d   = rerr_q;
        rdata_d  = rdata_q;
        for (int p = 0; p < 2; p++) begin
            if (gnt_o[p]) begin
                rvalid_d[p] = 1'b1;
                rerr_d[p]   = bad;
                rdata_d[p]  = bad ? 32'h0 : rom_instr_i;
            end else if (rready_i[p]) begin
                rvalid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rerr_q   <= '0;
            rdata_q  <= '0;
            last_q   <= 1'b1;
        end else begin
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            last_q   <= last_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_rom_arb.sv
// Directed and model-checked bench for rom_arb; inputs change 1 time unit after the rising edge.
module tb_rom_arb;
    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [1:0]         req_i = '0;
    logic [1:0]         rready_i = '0;
    logic [1:0][AW-1:0] addr_i = '0;
    logic [1:0]         gnt_o, rvalid_o, rerr_o;
    logic [1:0][31:0]   rdata_o;
    logic               rom_en_o;
    logic [AW-1:0]      rom_addr_o;
    logic [31:0]        rom_instr_i;
    logic [31:0]        rom [DEPTH];
    int                 checks = 0;
    int                 failures = 0;

    logic [1:0]         mv, me;
    logic [1:0][31:0]   md;
    logic               mlast;

    rom_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerr_o(rerr_o),
        .rready_i(rready_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
        .rom_instr_i(rom_instr_i)
    );

    always #5 clk_i = ~clk_i;

    // A disabled ROM returns garbage so a leaked read shows up in rdata.
    assign rom_instr_i = rom_en_o ? rom[rom_addr_o[6:2]] : 32'hDEAD_BEEF;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        #3;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        req_i = 2'b11; rready_i = 2'b11; addr_i = '0;
        #3;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
        checks++; if (rom_en_o !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%b exp=0", rom_en_o); end
        checks++; if (rom_addr_o !== '0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr_o); end
        checks++; if (rvalid_o !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", rvalid_o); end
        checks++; if (rdata_o !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
        checks++; if (rerr_o !== 2'b00) begin failures++; $display("FAIL reset_rerr got=%b exp=00", rerr_o); end
        cyc();
        rst_i = 1'b0;
        req_i = '0;
    endtask

    task automatic test_port0_reads();
        req_i = 2'b01; rready_i = 2'b11; addr_i[0] = 32'h0;
        #3;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL p0_gnt_n got=%b exp=01", gnt_o); end
        checks++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'h0) begin failures++; $display("FAIL p0_rom_n got=%b/%h exp=1/0", rom_en_o, rom_addr_o); end
        cyc();
        addr_i[0] = 32'h4;
        checks++; if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== 32'h0000_0013 || rerr_o[0] !== 1'b0)
            begin failures++; $display("FAIL p0_resp0 got=%b/%h/%b exp=1/00000013/0", rvalid_o[0], rdata_o[0], rerr_o[0]); end
        #2;
        checks++; if (gnt_o !== 2'b01 || rom_addr_o !== 32'h4) begin failures++; $display("FAIL p0_gnt_n1 got=%b/%h exp=01/4", gnt_o, rom_addr_o); end
        cyc();
        req_i = 2'b00;
        checks++; if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== 32'h00A0_0093 || rerr_o[0] !== 1'b0)
            begin failures++; $display("FAIL p0_resp1 got=%b/%h/%b exp=1/00a00093/0", rvalid_o[0], rdata_o[0], rerr_o[0]); end
        cyc();
        checks++; if (rvalid_o !== 2'b00) begin failures++; $display("FAIL p0_drain got=%b exp=00", rvalid_o); end
    endtask

    task automatic test_contention();
        logic [1:0]  eg;
        logic [31:0] ea, ed;
        do_reset();
        req_i = 2'b11; rready_i = 2'b11; addr_i[0] = 32'h8; addr_i[1] = 32'h7C;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            ea = (k % 2 == 1) ? 32'h7C : 32'h8;
            ed = (k % 2 == 1) ? rom[31] : rom[2];
            #3;
            checks++; if (gnt_o !== eg || rom_addr_o !== ea) begin failures++; $display("FAIL cont_gnt%0d got=%b/%h exp=%b/%h", k, gnt_o, rom_addr_o, eg, ea); end
            cyc();
            checks++; if (rdata_o[k % 2] !== ed || rvalid_o[k % 2] !== 1'b1) begin failures++; $display("FAIL cont_data%0d got=%h exp=%h", k, rdata_o[k % 2], ed); end
        end
        req_i = 2'b00;
        cyc();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_i = 2'b10; rready_i = 2'b01; addr_i[1] = 32'h10;
        #3;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL bp_first_gnt got=%b exp=10", gnt_o); end
        cyc();
        req_i = 2'b11; addr_i[0] = 32'h14; addr_i[1] = 32'h18;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL bp_gnt%0d got=%b exp=01", k, gnt_o); end
            checks++; if (rvalid_o[1] !== 1'b1 || rdata_o[1] !== rom[4]) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, rvalid_o[1], rdata_o[1], rom[4]); end
            cyc();
            checks++; if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== rom[5]) begin failures++; $display("FAIL bp_p0_%0d got=%b/%h exp=1/%h", k, rvalid_o[0], rdata_o[0], rom[5]); end
        end
        rready_i = 2'b11;
        #3;
        checks++; if (gnt_o !== 2'b10 || rom_addr_o !== 32'h18) begin failures++; $display("FAIL bp_release_gnt got=%b/%h exp=10/18", gnt_o, rom_addr_o); end
        cyc();
        req_i = 2'b00;
        checks++; if (rvalid_o[1] !== 1'b1 || rdata_o[1] !== rom[6]) begin failures++; $display("FAIL bp_reload got=%b/%h exp=1/%h", rvalid_o[1], rdata_o[1], rom[6]); end
        cyc();
    endtask

    task automatic test_errors();
        logic [31:0] ta [3];
        logic        te [3];
        logic [31:0] td [3];
        ta[0] = 32'h2;  te[0] = 1'b1; td[0] = 32'h0;
        ta[1] = 32'h80; te[1] = 1'b1; td[1] = 32'h0;
        ta[2] = 32'h7C; te[2] = 1'b0; td[2] = rom[31];
        req_i = 2'b01; rready_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            addr_i[0] = ta[k];
            #3;
            checks++; if (gnt_o !== 2'b01 || rom_en_o !== !te[k]) begin failures++; $display("FAIL err_gnt%0d got=%b/%b exp=01/%b", k, gnt_o, rom_en_o, !te[k]); end
            cyc();
            checks++; if (rvalid_o[0] !== 1'b1 || rerr_o[0] !== te[k] || rdata_o[0] !== td[k])
                begin failures++; $display("FAIL err_resp%0d got=%b/%h exp=%b/%h", k, rerr_o[0], rdata_o[0], te[k], td[k]); end
        end
        req_i = 2'b00;
        cyc();
    endtask

    task automatic test_mid_reset();
        req_i = 2'b11; rready_i = 2'b00; addr_i[0] = 32'h0; addr_i[1] = 32'h4;
        cyc();
        cyc();
        checks++; if (rvalid_o !== 2'b11 || rdata_o[0] !== rom[0] || rdata_o[1] !== rom[1])
            begin failures++; $display("FAIL mr_fill got=%b/%h/%h exp=11/%h/%h", rvalid_o, rdata_o[0], rdata_o[1], rom[0], rom[1]); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (rvalid_o !== 2'b00 || rdata_o !== '0) begin failures++; $display("FAIL mr_clear got=%b/%h exp=00/0", rvalid_o, rdata_o); end
        cyc();
        rst_i = 1'b0; rready_i = 2'b11;
        #3;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL mr_first_gnt got=%b exp=01", gnt_o); end
        cyc();
        req_i = 2'b00;
    endtask

    task automatic test_soak();
        logic [1:0]  elig, eg;
        logic [31:0] a;
        logic        bad;
        do_reset();
        mv = '0; me = '0; md = '0; mlast = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            req_i = 2'($urandom_range(0, 3));
            rready_i = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++)
                addr_i[p] = 32'($urandom_range(0, 40) * 4) + (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
            #3;
            elig = req_i & (~mv | rready_i);
            eg = (elig == 2'b11) ? (mlast ? 2'b01 : 2'b10) : elig;
            checks++; if (gnt_o !== eg) begin failures++; $display("FAIL soak_gnt n=%0d got=%b exp=%b", n, gnt_o, eg); end
            a = eg[1] ? addr_i[1] : addr_i[0];
            bad = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
            for (int p = 0; p < 2; p++) begin
                if (eg[p]) begin
                    mv[p] = 1'b1; me[p] = bad; md[p] = bad ? 32'h0 : rom[a[6:2]];
                end else if (rready_i[p]) begin
                    mv[p] = 1'b0;
                end
            end
            if (eg != 2'b00) mlast = eg[1];
            cyc();
            checks++; if (rvalid_o !== mv) begin failures++; $display("FAIL soak_rvalid n=%0d got=%b exp=%b", n, rvalid_o, mv); end
            for (int p = 0; p < 2; p++) begin
                if (mv[p]) begin
                    checks++;
                    if (rdata_o[p] !== md[p] || rerr_o[p] !== me[p])
                        begin failures++; $display("FAIL soak_resp n=%0d p=%0d got=%h/%b exp=%h/%b", n, p, rdata_o[p], rerr_o[p], md[p], me[p]); end
                end
            end
        end
        req_i = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
        rom[0]  = 32'h0000_0013;
        rom[1]  = 32'h00A0_0093;
        rom[31] = 32'hCAFE_F00D;
        test_reset();
        test_port0_reads();
        test_contention();
        test_backpressure();
        test_errors();
        test_mid_reset();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
